stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 CLK_HZ, 100000000, system clock frequency in Hz; CLK_HZ/4 SHALL be an integer of at least 2.
REQ-002 DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles required to accept a button level change; minimum 1.
REQ-003 clk  in  1  system clock; all logic rises on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 btn_pause  in  1  raw pause pushbutton, asynchronous, bouncy, active-high.
REQ-006 btn_rst  in  1  raw clear pushbutton, asynchronous, bouncy, active-high.
REQ-007 sw_adjust  in  1  raw adjust slide switch, asynchronous; 1 = adjust mode.
REQ-008 sw_select  in  1  raw field-select switch, asynchronous; 1 = seconds, 0 = minutes.
REQ-009 cnt_en  out  1  one-cycle increment strobe to the time counter.
REQ-010 cnt_field  out  1  field to increment: 0 = minutes, 1 = seconds; meaningful only in adjust states.
REQ-011 cnt_clear  out  1  one-cycle synchronous clear strobe to the time counter.
REQ-012 adj_mode  out  1  high in ADJ and ADJ_HOLD.
REQ-013 paused  out  1  high in PAUSE and ADJ_HOLD.
REQ-014 blink  out  1  2 Hz square wave for the display to flash the selected field.
REQ-015 state  out  2  current FSM state encoding.

Function
REQ-016 All four raw inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Each button SHALL be debounced: the debounced level takes the synchronized value only after that value has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-018 A press pulse SHALL be one cycle long and registered on each 0->1 transition of a debounced button level; one pulse per accepted press, none on release.
REQ-019 The tick generator SHALL produce a base pulse every CLK_HZ/4 cycles; tick_2hz on every 2nd base pulse; tick_1hz on every 4th base pulse; blink SHALL toggle on every base pulse.
REQ-020 FSM states: RUN=0, PAUSE=1, ADJ=2, ADJ_HOLD=3.
REQ-021 Pause press SHALL toggle RUN<->PAUSE and ADJ<->ADJ_HOLD.
REQ-022 Synchronized sw_adjust=1 SHALL move RUN->ADJ and PAUSE->ADJ_HOLD; sw_adjust=0 SHALL move ADJ->RUN and ADJ_HOLD->PAUSE.
REQ-023 When the pause press and an sw_adjust change occur in the same cycle, the state SHALL apply both (e.g. RUN + press + adjust rise -> ADJ_HOLD).
REQ-024 cnt_en SHALL be registered: it is asserted in the cycle after tick_1hz when the state in the tick cycle is RUN, or after tick_2hz when that state is ADJ; it is never asserted for PAUSE or ADJ_HOLD.
REQ-025 A press occurring in the same cycle as a tick SHALL NOT suppress that tick's cnt_en.
REQ-026 cnt_field SHALL be registered from synchronized sw_select, updated every cycle.
REQ-027 A clear press SHALL assert cnt_clear in the next cycle and restart the tick generator so that the next tick_1hz occurs a full CLK_HZ cycles later; the FSM state is unchanged.
REQ-028 cnt_en SHALL NOT be asserted in any cycle in which cnt_clear is asserted.

Reset
REQ-029 Reset SHALL force: state=RUN; cnt_en=0; cnt_clear=0; cnt_field=0; blink=0; adj_mode=0; paused=0; synchronizer flops, debounced levels and all counters=0.
REQ-030 Reset asserted mid-debounce or mid-tick SHALL discard the partial count; no press pulse SHALL be produced by a button held across reset release until it is released and pressed again.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the state enum and the cnt_field encoding (FIELD_MIN, FIELD_SEC).
REQ-032 Sub-module debounce (synchronizer, stable counter, level, rise pulse; DEBOUNCE_CYCLES parameter) SHALL be instantiated once per button.

Verification
REQ-033 CLK_HZ=16, DEBOUNCE_CYCLES=4, from reset: cnt_en every 16 cycles, blink period 8 cycles, paused=0, state=0.
REQ-034 btn_pause bounced 3 times within 3 cycles then held high for 10 cycles -> exactly one press pulse; state RUN->PAUSE; no cnt_en while paused; a second press -> RUN.
REQ-035 sw_adjust=1, sw_select=0 in RUN -> state=ADJ, adj_mode=1, cnt_en every 8 cycles, cnt_field=0; then pause press -> ADJ_HOLD, no cnt_en; then sw_adjust=0 -> PAUSE.
REQ-036 btn_rst press 5 cycles before a due tick -> single cnt_clear, no cnt_en in that cycle, next cnt_en 16 cycles after the clear.
REQ-037 Pause press aligned with tick_1hz in RUN -> cnt_en still asserted once, state=PAUSE afterwards.
REQ-038 btn_pause held high across reset release -> no press pulse until release and re-press; reset asserted mid-operation returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and encodings for the stopwatch controller.
package stopwatch_pkg;

   // Bit 1 = adjust, bit 0 = held (paused).
   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StPause   = 2'd1,
      StAdj     = 2'd2,
      StAdjHold = 2'd3
   } state_t;

   localparam logic FIELD_MIN = 1'b0;
   localparam logic FIELD_SEC = 1'b1;

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-flop synchronizer, stable-cycle counter, debounced level
// and a one-cycle press pulse on each accepted rising level.
module debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1, sync_q2;
   logic [1:0]    vld_q;
   logic          armed_q, armed_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronizer plus a marker that goes high once its output holds real samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         vld_q   <= 2'b00;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
         vld_q   <= {vld_q[0], 1'b1};
      end
   end

   // Stable-count debounce; until a stable low is seen the button is not armed, so a
   // button held through reset release never produces a press.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      armed_d = armed_q;
      press_d = 1'b0;
      if (!vld_q[1]) begin
         cnt_d = '0;
      end else if (!armed_q) begin
         if (sync_q2) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            armed_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (sync_q2 != level_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync_q2;
            press_d = sync_q2;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         armed_q <= armed_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button conditioning, 4 Hz base tick generator with 2 Hz/1 Hz
// derivatives, run/pause/adjust FSM and registered counter strobes.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100000000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_pause,
   input  logic       btn_rst,
   input  logic       sw_adjust,
   input  logic       sw_select,
   output logic       cnt_en,
   output logic       cnt_field,
   output logic       cnt_clear,
   output logic       adj_mode,
   output logic       paused,
   output logic       blink,
   output logic [1:0] state
);

   localparam int unsigned   BASE_CYCLES = CLK_HZ / 4;
   localparam int unsigned   BW          = $clog2(BASE_CYCLES);
   localparam logic [BW-1:0] BASE_LAST   = BW'(BASE_CYCLES - 1);

   logic          pause_press, clear_press;
   logic          adj_q1, adj_q2, sel_q1, sel_q2;
   logic [BW-1:0] base_cnt_q, base_cnt_d;
   logic [1:0]    phase_q, phase_d;
   logic          blink_q;
   logic          base_tick, tick_2hz, tick_1hz;
   state_t        state_q, state_d;
   logic          hold_next;
   logic          cnt_en_q, cnt_en_d, cnt_clear_q, cnt_field_q;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_pause),
      .press (pause_press)
   );

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_rst),
      .press (clear_press)
   );

   // Switch synchronizers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adj_q1 <= 1'b0;
         adj_q2 <= 1'b0;
         sel_q1 <= 1'b0;
         sel_q2 <= 1'b0;
      end else begin
         adj_q1 <= sw_adjust;
         adj_q2 <= adj_q1;
         sel_q1 <= sw_select;
         sel_q2 <= sel_q1;
      end
   end

   // Tick generator next state; a clear press restarts the whole 1 Hz period.
   always_comb begin
      base_tick  = (base_cnt_q == BASE_LAST);
      tick_2hz   = base_tick & phase_q[0];
      tick_1hz   = base_tick & (phase_q == 2'd3);
      base_cnt_d = base_cnt_q + 1'b1;
      phase_d    = phase_q;
      if (clear_press) begin
         base_cnt_d = '0;
         phase_d    = 2'd0;
      end else if (base_tick) begin
         base_cnt_d = '0;
         phase_d    = phase_q + 2'd1;
      end
   end

   // Tick generator registers; blink flips on every base tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_cnt_q <= '0;
         phase_q    <= 2'd0;
         blink_q    <= 1'b0;
      end else begin
         base_cnt_q <= base_cnt_d;
         phase_q    <= phase_d;
         if (base_tick) blink_q <= ~blink_q;
      end
   end

   // FSM next state: adjust bit follows the switch, held bit toggles on a press,
   // so simultaneous events combine.
   always_comb begin
      hold_next = (state_q inside {StPause, StAdjHold}) ^ pause_press;
      state_d   = state_q;
      case ({adj_q2, hold_next})
         2'b00:   state_d = StRun;
         2'b01:   state_d = StPause;
         2'b10:   state_d = StAdj;
         default: state_d = StAdjHold;
      endcase
      // Qualified by the state in the tick cycle, so a same-cycle press keeps the tick.
      cnt_en_d = ~clear_press & (((state_q == StRun) & tick_1hz) |
                                 ((state_q == StAdj) & tick_2hz));
   end

   // State and output strobe registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StRun;
         cnt_en_q    <= 1'b0;
         cnt_clear_q <= 1'b0;
         cnt_field_q <= FIELD_MIN;
      end else begin
         state_q     <= state_d;
         cnt_en_q    <= cnt_en_d;
         cnt_clear_q <= clear_press;
         cnt_field_q <= sel_q2 ? FIELD_SEC : FIELD_MIN;
      end
   end

   assign cnt_en    = cnt_en_q;
   assign cnt_clear = cnt_clear_q;
   assign cnt_field = cnt_field_q;
   assign blink     = blink_q;
   assign adj_mode  = state_q inside {StAdj, StAdjHold};
   assign paused    = state_q inside {StPause, StAdjHold};
   assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with CLK_HZ=16, DEBOUNCE_CYCLES=4.
// Cycle n counts posedges since reset release; cnt_en events are scoreboarded.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_pause = 1'b0, btn_rst = 1'b0, sw_adjust = 1'b0, sw_select = 1'b0;
   logic       cnt_en, cnt_field, cnt_clear, adj_mode, paused, blink;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int cyc;
   int exp_v;
   bit mon_en = 1'b0;
   int exp_q[$];

   always #5 clk = ~clk;

   stopwatch_ctrl #(.CLK_HZ(16), .DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_pause (btn_pause),
      .btn_rst   (btn_rst),
      .sw_adjust (sw_adjust),
      .sw_select (sw_select),
      .cnt_en    (cnt_en),
      .cnt_field (cnt_field),
      .cnt_clear (cnt_clear),
      .adj_mode  (adj_mode),
      .paused    (paused),
      .blink     (blink),
      .state     (state)
   );

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Scoreboard: every cnt_en must match the oldest expected cycle.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL cnt_en_missing: expected at cycle %0d, got no cnt_en", exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (cnt_en) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL cnt_en_unexpected: seen at cycle %0d, none expected", cyc);
            end else begin
               exp_v = exp_q.pop_front();
               if (cyc !== exp_v) begin
                  errors++;
                  $display("FAIL cnt_en_cycle: got cycle %0d, expected %0d", cyc, exp_v);
               end
            end
         end
         if (cnt_clear) begin
            checks++;
            if (cnt_en !== 1'b0) begin
               errors++;
               $display("FAIL cnt_en_with_clear: cnt_en=%b at cycle %0d, expected 0",
                        cnt_en, cyc);
            end
         end
      end
   end

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_reset(input logic hold_pause, input logic sel);
      mon_en    = 1'b0;
      reset     = 1'b1;
      btn_pause = hold_pause;
      btn_rst   = 1'b0;
      sw_adjust = 1'b0;
      sw_select = sel;
      repeat (3) @(negedge clk);
      exp_q.delete();
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_reset;
      mon_en    = 1'b0;
      reset     = 1'b1;
      btn_pause = 1'b1;
      sw_adjust = 1'b1;
      sw_select = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({state, cnt_en, cnt_clear, cnt_field, blink, adj_mode, paused} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b, expected 00000000",
                  {state, cnt_en, cnt_clear, cnt_field, blink, adj_mode, paused});
      end
      btn_pause = 1'b0;
      sw_adjust = 1'b0;
      sw_select = 1'b0;
      reset     = 1'b0;
      checks++;
      if ({state, cnt_en, cnt_clear, blink, paused} !== 6'h00) begin
         errors++;
         $display("FAIL reset_release: got %b, expected 000000",
                  {state, cnt_en, cnt_clear, blink, paused});
      end
   endtask

   task automatic test_run;
      logic exp_b;
      do_reset(1'b0, 1'b0);
      exp_q.push_back(16);
      exp_q.push_back(32);
      exp_q.push_back(48);
      for (int n = 1; n <= 52; n++) begin
         wait_until(n);
         exp_b = ((n / 4) % 2) == 1;
         checks++;
         if (blink !== exp_b) begin
            errors++;
            $display("FAIL run_blink: cycle %0d got %b, expected %b", n, blink, exp_b);
         end
         checks++;
         if ({state, paused, adj_mode} !== 4'b0000) begin
            errors++;
            $display("FAIL run_state: cycle %0d got %b, expected 0000", n,
                     {state, paused, adj_mode});
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL run_pending: %0d cnt_en still expected, expected 0", exp_q.size());
      end
   endtask

   task automatic test_pause;
      do_reset(1'b0, 1'b0);
      exp_q.push_back(16);
      exp_q.push_back(64);
      wait_until(20); btn_pause = 1'b1;
      wait_until(21); btn_pause = 1'b0;
      wait_until(22); btn_pause = 1'b1;
      wait_until(24);
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL pause_early: got state %0d, expected 0", state);
      end
      for (int n = 30; n <= 48; n++) begin
         wait_until(n);
         if (n == 32) btn_pause = 1'b0;
         if (n == 44) btn_pause = 1'b1;
         checks++;
         if (state !== 2'd1 || paused !== 1'b1) begin
            errors++;
            $display("FAIL pause_held: cycle %0d got state %0d paused %b, expected 1/1",
                     n, state, paused);
         end
      end
      for (int n = 53; n <= 70; n++) begin
         wait_until(n);
         if (n == 55) btn_pause = 1'b0;
         checks++;
         if (state !== 2'd0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL pause_resume: cycle %0d got state %0d paused %b, expected 0/0",
                     n, state, paused);
         end
      end
      wait_until(72);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pause_pending: %0d cnt_en still expected, expected 0", exp_q.size());
      end
   endtask

   task automatic test_adjust;
      do_reset(1'b0, 1'b0);
      for (int t = 16; t <= 48; t += 8) exp_q.push_back(t);
      wait_until(8); sw_adjust = 1'b1;
      wait_until(14);
      checks++;
      if ({state, adj_mode, paused, cnt_field} !== 5'b10100) begin
         errors++;
         $display("FAIL adj_enter: got %b, expected 10100", {state, adj_mode, paused, cnt_field});
      end
      wait_until(42); btn_pause = 1'b1;
      wait_until(50); btn_pause = 1'b0;
      wait_until(52);
      checks++;
      if ({state, adj_mode, paused} !== 4'b1111) begin
         errors++;
         $display("FAIL adj_hold: got %b, expected 1111", {state, adj_mode, paused});
      end
      wait_until(60); sw_adjust = 1'b0;
      wait_until(66);
      checks++;
      if ({state, adj_mode, paused} !== 4'b0101) begin
         errors++;
         $display("FAIL adj_exit: got %b, expected 0101", {state, adj_mode, paused});
      end
      wait_until(70); sw_select = 1'b1;
      wait_until(75);
      checks++;
      if (cnt_field !== 1'b1) begin
         errors++;
         $display("FAIL adj_field: got %b, expected 1", cnt_field);
      end
      wait_until(82);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL adj_pending: %0d cnt_en still expected, expected 0", exp_q.size());
      end
   endtask

   task automatic test_clear;
      logic exp_c;
      do_reset(1'b0, 1'b0);
      exp_q.push_back(16);
      exp_q.push_back(43);
      exp_q.push_back(75);
      for (int n = 1; n <= 80; n++) begin
         wait_until(n);
         if (n == 20) btn_rst = 1'b1;
         if (n == 30) btn_rst = 1'b0;
         if (n == 52) btn_rst = 1'b1;
         if (n == 62) btn_rst = 1'b0;
         exp_c = (n == 27) || (n == 59);
         checks++;
         if (cnt_clear !== exp_c || state !== 2'd0) begin
            errors++;
            $display("FAIL clear_strobe: cycle %0d got clear %b state %0d, expected %b/0",
                     n, cnt_clear, state, exp_c);
         end
      end
      wait_until(82);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL clear_pending: %0d cnt_en still expected, expected 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back;
      do_reset(1'b0, 1'b0);
      exp_q.push_back(16);
      exp_q.push_back(32);
      wait_until(25); btn_pause = 1'b1;
      wait_until(30);
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL aligned_before: got state %0d, expected 0", state);
      end
      for (int n = 33; n <= 60; n++) begin
         wait_until(n);
         if (n == 35) btn_pause = 1'b0;
         checks++;
         if (state !== 2'd1) begin
            errors++;
            $display("FAIL aligned_after: cycle %0d got state %0d, expected 1", n, state);
         end
      end
      wait_until(62);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL aligned_pending: %0d cnt_en still expected, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_hold;
      do_reset(1'b1, 1'b1);
      exp_q.push_back(16);
      exp_q.push_back(32);
      for (int n = 1; n <= 40; n++) begin
         wait_until(n);
         if (n == 20) btn_pause = 1'b0;
         if (n == 35) btn_pause = 1'b1;
         checks++;
         if (state !== 2'd0) begin
            errors++;
            $display("FAIL hold_no_press: cycle %0d got state %0d, expected 0", n, state);
         end
      end
      wait_until(45); btn_pause = 1'b0;
      wait_until(46);
      checks++;
      if ({state, paused, cnt_field} !== 4'b0111) begin
         errors++;
         $display("FAIL hold_repress: got %b, expected 0111", {state, paused, cnt_field});
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL hold_pending: %0d cnt_en still expected, expected 0", exp_q.size());
      end
      mon_en = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({state, cnt_en, cnt_clear, cnt_field, blink, adj_mode, paused} !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: got %b, expected 00000000",
                  {state, cnt_en, cnt_clear, cnt_field, blink, adj_mode, paused});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_run();
      test_pause();
      test_adjust();
      test_clear();
      test_back_to_back();
      test_reset_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
